// File: rtl/morra_pkg.sv
// Shared encodings and the move-dominance rule for the parametrised morra cinese engine.
package morra_pkg;

    typedef enum logic [1:0] {
        NO_MOVE  = 2'b00,
        ROCK     = 2'b01,
        PAPER    = 2'b10,
        SCISSORS = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        M_INVALID = 2'b00,
        M_PLAYER1 = 2'b01,
        M_PLAYER2 = 2'b10,
        M_NONE    = 2'b11
    } manche_t;

    typedef enum logic [1:0] {
        P_NOT_ENDED = 2'b00,
        P_P1_WINNER = 2'b01,
        P_P2_WINNER = 2'b10,
        P_DRAW      = 2'b11
    } partita_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_PLAYING = 2'b01,
        S_ENDED   = 2'b10
    } state_t;

    // Previous winner and the move it may not repeat; active=0 means no restriction.
    typedef struct packed {
        logic  active;
        logic  player2;
        move_t move;
    } restr_t;

    function automatic logic beats(move_t a, move_t b);
        return ((a == PAPER)    && (b == ROCK))     ||
               ((a == ROCK)     && (b == SCISSORS)) ||
               ((a == SCISSORS) && (b == PAPER));
    endfunction

endpackage

// File: rtl/morra_manche_judge.sv
// Combinational judge of a single manche, including the optional no-repeat restriction.
module morra_manche_judge
    import morra_pkg::*;
#(
    parameter int NO_REPEAT = 1
) (
    input  move_t   primo_i,
    input  move_t   secondo_i,
    input  restr_t  restr_i,
    output manche_t manche_o
);

    logic blocked;

    always_comb begin
        blocked = 1'b0;
        if ((NO_REPEAT != 0) && restr_i.active) begin
            blocked = restr_i.player2 ? (secondo_i == restr_i.move)
                                      : (primo_i == restr_i.move);
        end

        if ((primo_i == NO_MOVE) || (secondo_i == NO_MOVE) || blocked) begin
            manche_o = M_INVALID;
        end else if (beats(primo_i, secondo_i)) begin
            manche_o = M_PLAYER1;
        end else if (beats(secondo_i, primo_i)) begin
            manche_o = M_PLAYER2;
        end else begin
            manche_o = M_NONE;
        end
    end

endmodule

// File: rtl/morra_cinese_param.sv
// Game engine: FSM, round/score counters and end-of-partita check; one manche judged per clock.
module morra_cinese_param
    import morra_pkg::*;
#(
    parameter int CFG_W       = 4,
    parameter int MIN_ROUNDS  = 4,
    parameter int LEAD_MARGIN = 2,
    parameter int NO_REPEAT   = 1,
    parameter int RW          = $clog2(2**CFG_W + MIN_ROUNDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             INIZIA,
    input  logic [CFG_W-1:0] CFG,
    input  logic [1:0]       PRIMO,
    input  logic [1:0]       SECONDO,
    output logic [1:0]       MANCHE,
    output logic [1:0]       PARTITA,
    output logic [RW-1:0]    ROUNDS_PLAYED,
    output logic [RW-1:0]    SCORE_P1,
    output logic [RW-1:0]    SCORE_P2
);

    localparam logic [RW-1:0] MIN_R  = RW'(MIN_ROUNDS);
    localparam logic [RW-1:0] LEAD_R = RW'(LEAD_MARGIN);
    localparam logic [RW-1:0] ONE_R  = RW'(1);

    state_t        state_q;
    manche_t       manche_q;
    partita_t      partita_q;
    logic [RW-1:0] rounds_q, s1_q, s2_q, max_q;
    restr_t        restr_q;

    move_t         primo_mv, secondo_mv;
    manche_t       judge_res;
    logic          valid;
    logic [RW-1:0] rounds_d, s1_d, s2_d, diff_d;
    logic          early_end, limit_end;
    partita_t      leader_res;
    restr_t        restr_d;

    assign primo_mv   = move_t'(PRIMO);
    assign secondo_mv = move_t'(SECONDO);

    morra_manche_judge #(
        .NO_REPEAT (NO_REPEAT)
    ) u_judge (
        .primo_i   (primo_mv),
        .secondo_i (secondo_mv),
        .restr_i   (restr_q),
        .manche_o  (judge_res)
    );

    // Post-update values: the end check must see the manche being judged this cycle.
    always_comb begin
        valid    = (judge_res != M_INVALID);
        rounds_d = valid ? (rounds_q + ONE_R) : rounds_q;
        s1_d     = (judge_res == M_PLAYER1) ? (s1_q + ONE_R) : s1_q;
        s2_d     = (judge_res == M_PLAYER2) ? (s2_q + ONE_R) : s2_q;
        diff_d   = (s1_d > s2_d) ? (s1_d - s2_d) : (s2_d - s1_d);

        early_end = (rounds_d >= MIN_R) && (diff_d >= LEAD_R);
        limit_end = (rounds_d == max_q);

        if (s1_d > s2_d) begin
            leader_res = P_P1_WINNER;
        end else if (s2_d > s1_d) begin
            leader_res = P_P2_WINNER;
        end else begin
            leader_res = P_DRAW;
        end

        restr_d = '0;
        if (judge_res == M_PLAYER1) begin
            restr_d = '{active: 1'b1, player2: 1'b0, move: primo_mv};
        end else if (judge_res == M_PLAYER2) begin
            restr_d = '{active: 1'b1, player2: 1'b1, move: secondo_mv};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            manche_q  <= M_INVALID;
            partita_q <= P_NOT_ENDED;
            rounds_q  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            max_q     <= '0;
            restr_q   <= '0;
        end else if (INIZIA) begin
            state_q   <= S_PLAYING;
            manche_q  <= M_INVALID;
            partita_q <= P_NOT_ENDED;
            rounds_q  <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            max_q     <= RW'(CFG) + MIN_R;
            restr_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    manche_q  <= M_INVALID;
                    partita_q <= P_NOT_ENDED;
                end
                S_PLAYING: begin
                    manche_q <= judge_res;
                    if (valid) begin
                        rounds_q <= rounds_d;
                        s1_q     <= s1_d;
                        s2_q     <= s2_d;
                        restr_q  <= restr_d;
                        // A lead-margin end always has a strict leader, so leader_res serves both cases.
                        if (early_end || limit_end) begin
                            partita_q <= leader_res;
                            state_q   <= S_ENDED;
                        end else begin
                            partita_q <= P_NOT_ENDED;
                        end
                    end
                end
                S_ENDED: begin
                    manche_q <= M_INVALID;
                end
                default: begin
                    state_q   <= S_IDLE;
                    manche_q  <= M_INVALID;
                    partita_q <= P_NOT_ENDED;
                end
            endcase
        end
    end

    assign MANCHE        = manche_q;
    assign PARTITA       = partita_q;
    assign ROUNDS_PLAYED = rounds_q;
    assign SCORE_P1      = s1_q;
    assign SCORE_P2      = s2_q;

endmodule

// File: tb/tb_morra_cinese_param.sv
// Directed scoreboard bench for the default configuration and a reduced-parameter instance.
module tb_morra_cinese_param;

    localparam logic [1:0] NM = 2'b00, RK = 2'b01, PA = 2'b10, SC = 2'b11;

    typedef struct {
        logic [7:0] m;
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] s1;
        logic [7:0] s2;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1, ini = 1'b0;
    logic [3:0] cfg = '0;
    logic [1:0] p1 = NM, p2 = NM;
    logic [1:0] manche, partita;
    logic [4:0] rounds, s1, s2;

    logic       rst2 = 1'b1, ini2 = 1'b0;
    logic [1:0] cfg2 = '0;
    logic [1:0] q1 = NM, q2 = NM;
    logic [1:0] manche2, partita2;
    logic [2:0] rounds2, t1, t2;

    always #5 clk = ~clk;

    morra_cinese_param dut (
        .clk (clk), .rst (rst), .INIZIA (ini), .CFG (cfg),
        .PRIMO (p1), .SECONDO (p2),
        .MANCHE (manche), .PARTITA (partita),
        .ROUNDS_PLAYED (rounds), .SCORE_P1 (s1), .SCORE_P2 (s2)
    );

    morra_cinese_param #(
        .CFG_W (2), .MIN_ROUNDS (2), .LEAD_MARGIN (1), .NO_REPEAT (0)
    ) dut2 (
        .clk (clk), .rst (rst2), .INIZIA (ini2), .CFG (cfg2),
        .PRIMO (q1), .SECONDO (q2),
        .MANCHE (manche2), .PARTITA (partita2),
        .ROUNDS_PLAYED (rounds2), .SCORE_P1 (t1), .SCORE_P2 (t2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input logic [7:0] m, input logic [7:0] p, input logic [7:0] r,
                               input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, ".manche"},  m, e.m);
        chk({e.tag, ".partita"}, p, e.p);
        chk({e.tag, ".rounds"},  r, e.r);
        chk({e.tag, ".s1"},      a, e.s1);
        chk({e.tag, ".s2"},      b, e.s2);
        $display("step %-10s m=%0d p=%0d rounds=%0d s1=%0d s2=%0d", e.tag, m, p, r, a, b);
    endtask

    task automatic step(input logic r_i, input logic in_i, input logic [3:0] c_i,
                        input logic [1:0] a_i, input logic [1:0] b_i,
                        input int em, input int ep, input int er, input int e1, input int e2,
                        input string tag);
        @(negedge clk);
        rst = r_i; ini = in_i; cfg = c_i; p1 = a_i; p2 = b_i;
        sb.push_back('{m: 8'(em), p: 8'(ep), r: 8'(er), s1: 8'(e1), s2: 8'(e2), tag: tag});
        @(posedge clk);
        #1;
        compare_all({6'b0, manche}, {6'b0, partita}, {3'b0, rounds}, {3'b0, s1}, {3'b0, s2});
    endtask

    task automatic step2(input logic r_i, input logic in_i, input logic [1:0] c_i,
                         input logic [1:0] a_i, input logic [1:0] b_i,
                         input int em, input int ep, input int er, input int e1, input int e2,
                         input string tag);
        @(negedge clk);
        rst2 = r_i; ini2 = in_i; cfg2 = c_i; q1 = a_i; q2 = b_i;
        sb.push_back('{m: 8'(em), p: 8'(ep), r: 8'(er), s1: 8'(e1), s2: 8'(e2), tag: tag});
        @(posedge clk);
        #1;
        compare_all({6'b0, manche2}, {6'b0, partita2}, {5'b0, rounds2}, {5'b0, t1}, {5'b0, t2});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle behaviour
        step(1, 0, 4'h0, RK, PA, 0, 0, 0, 0, 0, "rst0");
        step(1, 0, 4'h0, RK, PA, 0, 0, 0, 0, 0, "rst1");
        step(0, 0, 4'h0, RK, PA, 0, 0, 0, 0, 0, "idle");
        // Short partita ending on lead margin at round 4
        step(0, 1, 4'h1, RK, PA, 0, 0, 0, 0, 0, "start1");
        step(0, 0, 4'h0, RK, PA, 2, 0, 1, 0, 1, "sp_r1");
        step(0, 0, 4'h0, SC, RK, 2, 0, 2, 0, 2, "sp_r2");
        step(0, 0, 4'h0, PA, SC, 2, 0, 3, 0, 3, "sp_r3");
        step(0, 0, 4'h0, SC, PA, 1, 2, 4, 1, 3, "sp_r4");
        step(0, 0, 4'h0, RK, SC, 0, 2, 4, 1, 3, "sp_ended");
        // Invalid moves, draws and the no-repeat rule
        step(0, 1, 4'hF, NM, NM, 0, 0, 0, 0, 0, "start2");
        step(0, 0, 4'h0, NM, PA, 0, 0, 0, 0, 0, "nomove");
        step(0, 0, 4'h0, RK, RK, 3, 0, 1, 0, 0, "draw");
        step(0, 0, 4'h0, PA, RK, 1, 0, 2, 1, 0, "p1win");
        step(0, 0, 4'h0, PA, SC, 0, 0, 2, 1, 0, "norepeat");
        step(0, 0, 4'h0, RK, PA, 2, 0, 3, 1, 1, "p2win");
        // Round limit reached on a tie
        step(0, 1, 4'h0, NM, NM, 0, 0, 0, 0, 0, "start3");
        step(0, 0, 4'h0, PA, RK, 1, 0, 1, 1, 0, "lim_r1");
        step(0, 0, 4'h0, RK, PA, 2, 0, 2, 1, 1, "lim_r2");
        step(0, 0, 4'h0, SC, SC, 3, 0, 3, 1, 1, "lim_r3");
        step(0, 0, 4'h0, RK, RK, 3, 3, 4, 1, 1, "lim_r4");
        // Restart mid-partita, then reset overriding INIZIA
        step(0, 1, 4'hF, NM, NM, 0, 0, 0, 0, 0, "start4");
        step(0, 0, 4'h0, PA, RK, 1, 0, 1, 1, 0, "rs_r1");
        step(0, 0, 4'h0, SC, PA, 1, 0, 2, 2, 0, "rs_r2");
        step(0, 0, 4'h0, PA, SC, 2, 0, 3, 2, 1, "rs_r3");
        step(0, 1, 4'h1, RK, SC, 0, 0, 0, 0, 0, "restart");
        step(0, 0, 4'h0, RK, SC, 1, 0, 1, 1, 0, "rs_play");
        step(1, 1, 4'h1, RK, SC, 0, 0, 0, 0, 0, "rst_ini");
        step(0, 0, 4'h0, RK, SC, 0, 0, 0, 0, 0, "idle2");
        // Reduced-parameter instance: lead 1 after 2 rounds, repeats allowed
        step2(1, 0, 2'h0, NM, NM, 0, 0, 0, 0, 0, "b_rst");
        step2(0, 1, 2'h2, NM, NM, 0, 0, 0, 0, 0, "b_start");
        step2(0, 0, 2'h0, RK, SC, 1, 0, 1, 1, 0, "b_r1");
        step2(0, 0, 2'h0, RK, SC, 1, 1, 2, 2, 0, "b_repeat");
        step2(0, 1, 2'h0, NM, NM, 0, 0, 0, 0, 0, "b_start2");
        step2(0, 0, 2'h0, RK, RK, 3, 0, 1, 0, 0, "b_d1");
        step2(0, 0, 2'h0, PA, PA, 3, 3, 2, 0, 0, "b_d2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
